// File: rtl/sine_ctrl_rx_if.sv
// Byte-stream link from the UART receiver into the command decoder.
// One-cycle strobe per byte; there is no backpressure.
interface sine_ctrl_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/sine_ctrl_rx.sv
// Framed command decoder feeding the sine/modulation generator: parses A5/CMD/payload/CHK
// packets, validates them and commits tuning word and mode atomically.
module sine_ctrl_rx #(
    parameter int unsigned TIMEOUT_CYC = 100_000,
    parameter logic [31:0] FW_RESET    = 32'd42_949_673,
    parameter logic [31:0] FW_MAX      = 32'h7FFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    sine_ctrl_rx_if.slave rx,
    output logic [31:0]   freq_c,
    output logic [5:0]    flag_mod,
    output logic          upd,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic          busy
);
    localparam logic [7:0]      SOF     = 8'hA5;
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_PAY, ST_SUM, ST_CHECK} state_t;

    state_t          state;
    logic [7:0]      cmd_q;
    logic [7:0]      xor_q;
    logic [7:0]      chk_q;
    logic [39:0]     shadow_q;
    logic [2:0]      pay_cnt;
    logic [TO_W-1:0] to_cnt;

    logic [2:0]  cmd_len;
    logic        in_pkt;
    logic        timed_out;
    logic        sof_seen;
    logic        has_word;
    logic        has_mode;
    logic        pkt_ok;
    logic        reject;
    logic [31:0] word_sh;
    logic [7:0]  mode_sh;

    function automatic logic mode_legal(input logic [7:0] m);
        if (m[7:6] != 2'b00) return 1'b0;
        case (m[5:0])
            6'b000000, 6'b010101, 6'b011010, 6'b110000, 6'b110001: return 1'b1;
            default: return (m[5:0] >= 6'b100001) && (m[5:0] <= 6'b101010);
        endcase
    endfunction

    // NOTE: each always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        cmd_len = 3'd0;
        case (rx.rx_data)
            8'h01:   cmd_len = 3'd4;
            8'h02:   cmd_len = 3'd1;
            8'h03:   cmd_len = 3'd5;
            default: cmd_len = 3'd0;
        endcase

        in_pkt    = (state == ST_CMD) || (state == ST_PAY) || (state == ST_SUM);
        timed_out = in_pkt && !rx.rx_valid && (to_cnt == TO_LAST);
        sof_seen  = rx.rx_valid && (rx.rx_data == SOF);

        // Mode is always the last payload byte; the word sits above it for CMD 0x03.
        has_word = (cmd_q == 8'h01) || (cmd_q == 8'h03);
        has_mode = (cmd_q == 8'h02) || (cmd_q == 8'h03);
        word_sh  = (cmd_q == 8'h03) ? shadow_q[39:8] : shadow_q[31:0];
        mode_sh  = shadow_q[7:0];
        pkt_ok   = (xor_q == chk_q)
                && (!has_word || (word_sh <= FW_MAX))
                && (!has_mode || mode_legal(mode_sh));

        reject = timed_out
              || ((state == ST_CMD) && rx.rx_valid && (cmd_len == 3'd0))
              || ((state == ST_CHECK) && !pkt_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            xor_q    <= '0;
            chk_q    <= '0;
            shadow_q <= '0;
            pay_cnt  <= '0;
            to_cnt   <= '0;
            freq_c   <= FW_RESET;
            flag_mod <= '0;
            upd      <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            upd <= 1'b0;
            err <= reject;
            if (reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if (!in_pkt || rx.rx_valid) to_cnt <= '0;
            else                        to_cnt <= to_cnt + 1'b1;

            if (timed_out) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                shadow_q <= '0;
                xor_q    <= '0;
                chk_q    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sof_seen) begin
                            state <= ST_CMD;
                            busy  <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (rx.rx_valid) begin
                            if (cmd_len == 3'd0) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= ST_PAY;
                                cmd_q    <= rx.rx_data;
                                xor_q    <= rx.rx_data;
                                shadow_q <= '0;
                                pay_cnt  <= cmd_len;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (rx.rx_valid) begin
                            shadow_q <= {shadow_q[31:0], rx.rx_data};
                            xor_q    <= xor_q ^ rx.rx_data;
                            pay_cnt  <= pay_cnt - 3'd1;
                            if (pay_cnt == 3'd1) state <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        if (rx.rx_valid) begin
                            chk_q <= rx.rx_data;
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (pkt_ok) begin
                            if (has_word) freq_c   <= word_sh;
                            if (has_mode) flag_mod <= mode_sh[5:0];
                            upd <= 1'b1;
                        end
                        // A start byte landing in this cycle opens the next packet directly.
                        state <= sof_seen ? ST_CMD : ST_IDLE;
                        busy  <= sof_seen;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
